// File: rtl/mate_sched.sv
// mate_sched: walks two parent genomes through one crossover PE
// and writes the child genome, terminated by an all-zero word.
module mate_sched #(
    parameter int WORD_SIZE   = 32,
    parameter int GENOME_SIZE = 32,
    parameter int ADDR_W      = 8,
    parameter int PE_LAT      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WORD_SIZE-1:0]   job_ctrl,
    input  logic [ADDR_W-1:0]      p1_base,
    input  logic [ADDR_W-1:0]      p2_base,
    input  logic [ADDR_W-1:0]      ch_base,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             child_len,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [GENOME_SIZE-1:0] rd_data,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [GENOME_SIZE-1:0] wr_data,
    output logic                   pe_control_req,
    output logic [WORD_SIZE-1:0]   pe_control_bus,
    output logic                   pe_data_valid,
    output logic [GENOME_SIZE-1:0] pe_in_bus,
    input  logic [GENOME_SIZE-1:0] pe_out_bus
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CFG   = 4'd1;
    localparam logic [3:0] S_RD1   = 4'd2;
    localparam logic [3:0] S_RD2   = 4'd3;
    localparam logic [3:0] S_FEED1 = 4'd4;
    localparam logic [3:0] S_FEED2 = 4'd5;
    localparam logic [3:0] S_WAIT  = 4'd6;
    localparam logic [3:0] S_CAP   = 4'd7;
    localparam logic [3:0] S_TERM  = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    localparam logic [7:0] LAT_LAST = 8'(PE_LAT - 1);

    logic [3:0]        state;
    logic [ADDR_W-1:0] p1_q;
    logic [ADDR_W-1:0] p2_q;
    logic [ADDR_W-1:0] ch_q;
    logic [7:0]        s1_q;
    logic [7:0]        s2_q;
    logic [7:0]        n_q;
    logic [7:0]        i_q;
    logic [7:0]        c_q;
    logic [7:0]        wcnt_q;

    logic [7:0] sz1;
    logic [7:0] sz2;
    logic [7:0] i_nx;

    assign sz1  = job_ctrl[23:16];
    assign sz2  = job_ctrl[31:24];
    assign i_nx = i_q + 8'd1;

    // Sequencer: every output is a flop loaded with the value that belongs
    // to the state being entered, so strobes line up with the state cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            p1_q           <= '0;
            p2_q           <= '0;
            ch_q           <= '0;
            s1_q           <= '0;
            s2_q           <= '0;
            n_q            <= '0;
            i_q            <= '0;
            c_q            <= '0;
            wcnt_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            child_len      <= '0;
            rd_en          <= 1'b0;
            rd_addr        <= '0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            pe_control_req <= 1'b0;
            pe_control_bus <= '0;
            pe_data_valid  <= 1'b0;
            pe_in_bus      <= '0;
        end else begin
            rd_en          <= 1'b0;
            wr_en          <= 1'b0;
            pe_control_req <= 1'b0;
            pe_data_valid  <= 1'b0;
            done           <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_CFG;
                        busy           <= 1'b1;
                        child_len      <= '0;
                        p1_q           <= p1_base;
                        p2_q           <= p2_base;
                        ch_q           <= ch_base;
                        s1_q           <= sz1;
                        s2_q           <= sz2;
                        n_q            <= (sz1 > sz2) ? sz1 : sz2;
                        i_q            <= '0;
                        c_q            <= '0;
                        pe_control_req <= 1'b1;
                        pe_control_bus <= job_ctrl;
                    end
                end
                S_CFG: begin
                    if (n_q == 8'd0) begin
                        state   <= S_TERM;
                        wr_en   <= 1'b1;
                        wr_addr <= ch_q + ADDR_W'(c_q);
                        wr_data <= '0;
                    end else begin
                        state   <= S_RD1;
                        rd_en   <= 1'b1;
                        rd_addr <= p1_q + ADDR_W'(i_q);
                    end
                end
                S_RD1: begin
                    state   <= S_RD2;
                    rd_en   <= 1'b1;
                    rd_addr <= p2_q + ADDR_W'(i_q);
                end
                S_RD2: begin
                    state         <= S_FEED1;
                    pe_data_valid <= 1'b1;
                    pe_in_bus     <= (i_q < s1_q) ? rd_data : '0;
                end
                S_FEED1: begin
                    state         <= S_FEED2;
                    pe_data_valid <= 1'b1;
                    pe_in_bus     <= (i_q < s2_q) ? rd_data : '0;
                end
                S_FEED2: begin
                    state  <= S_WAIT;
                    wcnt_q <= '0;
                end
                S_WAIT: begin
                    if (wcnt_q == LAT_LAST) begin
                        state <= S_CAP;
                        if (pe_out_bus != '0) begin
                            wr_en   <= 1'b1;
                            wr_addr <= ch_q + ADDR_W'(c_q);
                            wr_data <= pe_out_bus;
                            c_q     <= c_q + 8'd1;
                        end
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                S_CAP: begin
                    i_q <= i_nx;
                    if (i_nx == n_q) begin
                        state   <= S_TERM;
                        wr_en   <= 1'b1;
                        wr_addr <= ch_q + ADDR_W'(c_q);
                        wr_data <= '0;
                    end else begin
                        state   <= S_RD1;
                        rd_en   <= 1'b1;
                        rd_addr <= p1_q + ADDR_W'(i_nx);
                    end
                end
                S_TERM: begin
                    state     <= S_DONE;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    child_len <= c_q;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
